lcd_capture: RTL and testbench

Receives a parallel RGB video stream (VS/HS/DE plus 24-bit RGB, qualified by a pixel strobe) and packs it into 64-bit words for the write port of `sdram_top`. It is the input-side counterpart of the LCD timing/output path, and it produces the frame buffer that the LCD read path later scans out. Each pixel is converted to RGB565, and four pixels are packed per SDRAM word. Every valid frame start pulses `wr_load` so that SDRAM writes restart at `wr_min_addr`. Frame geometry is checked against parameters, and the result is reported per frame.

---
 rtl/lcd_capture.sv | 151 +++++++++++++++
 tb/tb_lcd_capture.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_capture.sv
// lcd_capture: samples strobed RGB888 video, converts it to RGB565 and packs four pixels per 64-bit SDRAM write word.
// Latency: wr_en/wr_data, wr_load and frame_done/frame_err are registered one cycle after the pix_ce cycle that causes them.
// Backpressure: none; the SDRAM write FIFO must absorb at most one wr_en every four cycles.
module lcd_capture #(
    parameter int H_DISP   = 480,
    parameter int V_DISP   = 272,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        i_clk_50m,
    input  logic        i_rst,
    input  logic        i_pix_ce,
    input  logic        i_vid_vs,
    input  logic        i_vid_hs,
    input  logic        i_vid_de,
    input  logic [23:0] i_vid_rgb,
    input  logic        i_sdram_init_done,
    output logic        o_wr_en,
    output logic [63:0] o_wr_data,
    output logic        o_wr_load,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic [7:0]  o_frame_cnt
);

    localparam logic [10:0] LP_H = 11'(H_DISP);
    localparam logic [9:0]  LP_V = 10'(V_DISP);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_CAP} state_t;

    state_t      r_state;
    logic        r_vs_prev;
    logic        r_de_prev;
    logic [10:0] r_pix_cnt;
    logic [9:0]  r_line_cnt;
    logic [1:0]  r_pix_idx;
    logic        r_err;
    logic [47:0] r_word;

    // hsync carries no information the capture logic needs
    logic w_unused_hs;
    assign w_unused_hs = i_vid_hs;

    logic        w_fse;
    logic        w_line_end;
    logic        w_pix;
    logic        w_active;
    logic [10:0] w_pc_base;
    logic [9:0]  w_lc_base;
    logic [1:0]  w_idx_base;
    logic        w_err_base;
    logic        w_pix_ok;
    logic [10:0] w_pc_inc;
    logic [9:0]  w_lc_inc;
    logic        w_frame_good;
    logic [15:0] w_565;

    assign w_fse      = i_pix_ce && (i_vid_vs == SYNC_POL) && (r_vs_prev != SYNC_POL);
    assign w_line_end = i_pix_ce && !i_vid_de && r_de_prev;
    assign w_pix      = i_pix_ce && i_vid_de;
    assign w_565      = {i_vid_rgb[23:19], i_vid_rgb[15:10], i_vid_rgb[7:3]};

    // A frame start is processed before a pixel in the same cycle, so the
    // pixel logic works from counters that are already cleared by the FSE.
    assign w_active   = (r_state == ST_CAP) || ((r_state == ST_SYNC) && w_fse);
    assign w_pc_base  = w_fse ? 11'd0 : r_pix_cnt;
    assign w_lc_base  = w_fse ? 10'd0 : r_line_cnt;
    assign w_idx_base = w_fse ? 2'd0  : r_pix_idx;
    assign w_err_base = w_fse ? 1'b0  : r_err;
    assign w_pix_ok   = w_pix && (w_lc_base < LP_V) && (w_pc_base < LP_H);
    assign w_pc_inc   = (w_pc_base == 11'h7FF) ? w_pc_base : w_pc_base + 11'd1;
    assign w_lc_inc   = (r_line_cnt == 10'h3FF) ? r_line_cnt : r_line_cnt + 10'd1;
    assign w_frame_good = (r_line_cnt == LP_V) && !r_err;

    // Capture FSM: init gating, frame sync, pixel packing and geometry check
    always_ff @(posedge i_clk_50m) begin
        o_wr_en      <= 1'b0;
        o_wr_load    <= 1'b0;
        o_frame_done <= 1'b0;
        o_frame_err  <= 1'b0;
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_vs_prev   <= 1'b0;
            r_de_prev   <= 1'b0;
            r_pix_cnt   <= 11'd0;
            r_line_cnt  <= 10'd0;
            r_pix_idx   <= 2'd0;
            r_err       <= 1'b0;
            r_word      <= 48'd0;
            o_wr_data   <= 64'd0;
            o_frame_cnt <= 8'd0;
        end else begin
            if (i_pix_ce) begin
                r_vs_prev <= i_vid_vs;
                r_de_prev <= i_vid_de;
            end
            if (!i_sdram_init_done) begin
                // losing the SDRAM abandons the frame silently
                r_state <= ST_IDLE;
            end else begin
                if (r_state == ST_IDLE) begin
                    r_state <= ST_SYNC;
                end
                if (w_active) begin
                    r_state    <= ST_CAP;
                    r_pix_cnt  <= w_pc_base;
                    r_line_cnt <= w_lc_base;
                    r_pix_idx  <= w_idx_base;
                    r_err      <= w_err_base;
                    if (w_fse) begin
                        o_wr_load <= 1'b1;
                        if (r_state == ST_CAP) begin
                            if (w_frame_good) begin
                                o_frame_done <= 1'b1;
                                o_frame_cnt  <= o_frame_cnt + 8'd1;
                            end else begin
                                o_frame_err <= 1'b1;
                            end
                        end
                    end
                    if (w_pix) begin
                        r_pix_cnt <= w_pc_inc;
                        if (w_pix_ok) begin
                            r_pix_idx <= w_idx_base + 2'd1;
                            case (w_idx_base)
                                2'd0: r_word[47:32] <= w_565;
                                2'd1: r_word[31:16] <= w_565;
                                2'd2: r_word[15:0]  <= w_565;
                                2'd3: begin
                                    o_wr_en   <= 1'b1;
                                    o_wr_data <= {r_word, w_565};
                                end
                            endcase
                        end else begin
                            // overlong line or surplus line: drop pixel, flag frame
                            r_err <= 1'b1;
                        end
                    end else if (w_line_end && !w_fse) begin
                        // partial word is dropped by resetting the slot index
                        if (r_pix_cnt != LP_H) begin
                            r_err <= 1'b1;
                        end
                        r_pix_cnt  <= 11'd0;
                        r_pix_idx  <= 2'd0;
                        r_line_cnt <= w_lc_inc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_capture.sv
module tb_lcd_capture;

    localparam int H = 8;
    localparam int V = 2;

    logic        i_clk_50m = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pix_ce = 1'b0;
    logic        i_vid_vs = 1'b0;
    logic        i_vid_hs = 1'b0;
    logic        i_vid_de = 1'b0;
    logic [23:0] i_vid_rgb = 24'd0;
    logic        i_sdram_init_done = 1'b1;
    logic        o_wr_en;
    logic [63:0] o_wr_data;
    logic        o_wr_load;
    logic        o_frame_done;
    logic        o_frame_err;
    logic [7:0]  o_frame_cnt;

    lcd_capture #(.H_DISP(H), .V_DISP(V), .SYNC_POL(1'b1)) dut (
        .i_clk_50m(i_clk_50m),
        .i_rst(i_rst),
        .i_pix_ce(i_pix_ce),
        .i_vid_vs(i_vid_vs),
        .i_vid_hs(i_vid_hs),
        .i_vid_de(i_vid_de),
        .i_vid_rgb(i_vid_rgb),
        .i_sdram_init_done(i_sdram_init_done),
        .o_wr_en(o_wr_en),
        .o_wr_data(o_wr_data),
        .o_wr_load(o_wr_load),
        .o_frame_done(o_frame_done),
        .o_frame_err(o_frame_err),
        .o_frame_cnt(o_frame_cnt)
    );

    always #5 i_clk_50m = ~i_clk_50m;

    int cyc = 0;
    always @(posedge i_clk_50m) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [63:0] d;
        int          c;
    } wr_t;
    wr_t wq[$];

    // reference model state
    bit          m_init = 1'b1;
    bit          m_cap = 1'b0;
    int          m_line = 0;
    bit          m_ok = 1'b1;
    int          m_fcnt = 0;
    int          gap = 1;
    logic [23:0] lp[16];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] c565(input logic [23:0] p);
        return {p[23:19], p[15:10], p[7:3]};
    endfunction

    // write monitor: every wr_en must match the next expected word and cycle
    always @(negedge i_clk_50m) begin
        while (wq.size() > 0 && wq[0].c < cyc) begin
            chk("wr_missed_cycle", 64'(cyc), 64'(wq[0].c));
            void'(wq.pop_front());
        end
        if (o_wr_en) begin
            if (wq.size() == 0) begin
                chk("wr_unexpected", {63'd0, o_wr_en}, 64'd0);
            end else begin
                chk("wr_cycle", 64'(cyc), 64'(wq[0].c));
                chk("wr_data", o_wr_data, wq[0].d);
                void'(wq.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk_50m);
            i_pix_ce  = 1'b0;
            i_vid_rgb = 24'($urandom);
        end
    endtask

    // one strobed sample, preceded by gap-1 non-strobe cycles of junk
    task automatic ce_cycle(input logic vs, input logic de, input logic [23:0] rgb);
        for (int g = 1; g < gap; g++) begin
            @(negedge i_clk_50m);
            i_pix_ce  = 1'b0;
            i_vid_vs  = 1'($urandom);
            i_vid_de  = 1'($urandom);
            i_vid_rgb = 24'($urandom);
        end
        @(negedge i_clk_50m);
        i_pix_ce  = 1'b1;
        i_vid_vs  = vs;
        i_vid_de  = de;
        i_vid_rgb = rgb;
    endtask

    task automatic fill_random(input int len);
        for (int k = 0; k < len; k++) lp[k] = 24'($urandom);
    endtask

    task automatic push_word(input int k);
        wr_t w;
        w.d = {c565(lp[k-3]), c565(lp[k-2]), c565(lp[k-1]), c565(lp[k])};
        w.c = cyc + 1;
        wq.push_back(w);
    endtask

    // send lp[0..len-1] as one DE run followed by a line-end sample
    task automatic send_line(input int len);
        for (int k = 0; k < len; k++) begin
            ce_cycle(1'b0, 1'b1, lp[k]);
            if (m_cap && m_line < V && k < H && (k % 4) == 3) push_word(k);
        end
        ce_cycle(1'b0, 1'b0, 24'($urandom));
        if (m_cap) begin
            if (m_line >= V || len != H) m_ok = 1'b0;
            m_line++;
        end
    endtask

    task automatic send_fse(input string tag);
        bit good;
        bit eload;
        bit edone;
        bit eerr;
        good  = (m_line == V) && m_ok;
        eload = m_init;
        edone = m_cap && good;
        eerr  = m_cap && !good;
        if (edone) m_fcnt = (m_fcnt + 1) % 256;
        ce_cycle(1'b1, 1'b0, 24'($urandom));
        @(negedge i_clk_50m);
        chk({tag, "_wr_load"}, {63'd0, o_wr_load}, {63'd0, eload});
        chk({tag, "_frame_done"}, {63'd0, o_frame_done}, {63'd0, edone});
        chk({tag, "_frame_err"}, {63'd0, o_frame_err}, {63'd0, eerr});
        chk({tag, "_frame_cnt"}, {56'd0, o_frame_cnt}, 64'(m_fcnt));
        i_pix_ce = 1'b0;
        i_vid_vs = 1'b0;
        m_cap  = m_init;
        m_line = 0;
        m_ok   = 1'b1;
    endtask

    task automatic good_frame(input string tag);
        for (int l = 0; l < V; l++) begin
            fill_random(H);
            send_line(H);
        end
        send_fse(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_en"}, {63'd0, o_wr_en}, 64'd0);
        chk({tag, "_wr_data"}, o_wr_data, 64'd0);
        chk({tag, "_wr_load"}, {63'd0, o_wr_load}, 64'd0);
        chk({tag, "_frame_done"}, {63'd0, o_frame_done}, 64'd0);
        chk({tag, "_frame_err"}, {63'd0, o_frame_err}, 64'd0);
        chk({tag, "_frame_cnt"}, {56'd0, o_frame_cnt}, 64'd0);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge i_clk_50m);
        check_all_zero("reset");
        i_rst = 1'b0;
        idle(3);

        // first frame start out of SYNC: load only
        send_fse("first_fse");

        // basic frame: ramp pixels, two full lines
        for (int l = 0; l < V; l++) begin
            for (int k = 0; k < H; k++) lp[k] = 24'(k * 32'h0020_1008 + l * 32'h0008_0808);
            send_line(H);
        end
        send_fse("basic");

        // packing of the four primary patterns into the last word of a line
        fill_random(4);
        lp[4] = 24'hFF0000;
        lp[5] = 24'h00FF00;
        lp[6] = 24'h0000FF;
        lp[7] = 24'hFFFFFF;
        send_line(H);
        chk("pack_word", o_wr_data, 64'hF800_07E0_001F_FFFF);
        fill_random(H);
        send_line(H);
        send_fse("pack");

        // strobe every third cycle with junk between strobes
        gap = 3;
        good_frame("gap3");
        gap = 1;

        // short first line: one word only, frame reported bad
        fill_random(6);
        send_line(6);
        fill_random(H);
        send_line(H);
        send_fse("short");

        // reset after five pixels of a new frame
        fill_random(H);
        for (int k = 0; k < 5; k++) begin
            ce_cycle(1'b0, 1'b1, lp[k]);
            if (k == 3) push_word(k);
        end
        @(negedge i_clk_50m);
        i_pix_ce = 1'b0;
        i_rst    = 1'b1;
        @(negedge i_clk_50m);
        check_all_zero("midrst");
        i_rst  = 1'b0;
        m_cap  = 1'b0;
        m_line = 0;
        m_ok   = 1'b1;
        m_fcnt = 0;
        idle(3);
        fill_random(H);
        send_line(H);
        send_fse("post_rst_fse");
        good_frame("post_rst");

        // init gating: drop init mid-frame, run a frame, raise it mid-frame
        fill_random(H);
        send_line(H);
        @(negedge i_clk_50m);
        i_pix_ce = 1'b0;
        i_sdram_init_done = 1'b0;
        m_init = 1'b0;
        m_cap  = 1'b0;
        idle(2);
        fill_random(H);
        send_line(H);
        send_fse("noinit");
        fill_random(H);
        send_line(H);
        @(negedge i_clk_50m);
        i_pix_ce = 1'b0;
        i_sdram_init_done = 1'b1;
        m_init = 1'b1;
        idle(2);
        fill_random(H);
        send_line(H);
        send_fse("init_up");
        good_frame("after_init");

        // randomized frame geometry and strobe spacing
        for (int f = 0; f < 8; f++) begin
            int nl;
            int len;
            gap = $urandom_range(1, 3);
            nl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : V;
            for (int l = 0; l < nl; l++) begin
                len = ($urandom_range(0, 2) == 0) ? $urandom_range(4, 11) : H;
                fill_random(len);
                send_line(len);
            end
            send_fse("rand");
        end
        gap = 1;

        idle(6);
        chk("writes_pending", 64'(wq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
